// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the typing-game session controller: FSM state
// encoding, mode codes, counter width and ceiling, per-mode hit weights and
// miss penalties, plus saturating add / floored subtract helpers used by the
// counter logic.
// Ports: none (package).
// ---------------------------------------------------------------------------
package game_pkg;

  // Width of every displayed counter and the value they saturate at.
  localparam int CNT_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = 14'd9999;

  // Session states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  // Mode codes as seen on mode_sel / mode; code 11 is never latched.
  typedef enum logic [1:0] {
    MODE_AMA     = 2'b00,
    MODE_PRO     = 2'b01,
    MODE_EDL     = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  // Points added for a correct keystroke, per mode.
  localparam logic [1:0] HIT_AMA = 2'd1;
  localparam logic [1:0] HIT_PRO = 2'd2;
  localparam logic [1:0] HIT_EDL = 2'd3;

  // Points removed for a missed keystroke, per mode.
  localparam logic [1:0] PEN_AMA = 2'd0;
  localparam logic [1:0] PEN_PRO = 2'd1;
  localparam logic [1:0] PEN_EDL = 2'd2;

  // Hit weight lookup; the illegal code can never be the active mode,
  // so it simply yields zero.
  function automatic logic [1:0] hit_weight(input logic [1:0] m);
    case (m)
      MODE_AMA: return HIT_AMA;
      MODE_PRO: return HIT_PRO;
      MODE_EDL: return HIT_EDL;
      default:  return 2'd0;
    endcase
  endfunction

  // Miss penalty lookup, same convention as hit_weight.
  function automatic logic [1:0] miss_penalty(input logic [1:0] m);
    case (m)
      MODE_AMA: return PEN_AMA;
      MODE_PRO: return PEN_PRO;
      MODE_EDL: return PEN_EDL;
      default:  return 2'd0;
    endcase
  endfunction

  // Add a small increment using a one-bit-wider intermediate, then clamp
  // to CNT_MAX so the counter never wraps upward.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > {1'b0, CNT_MAX}) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  // Subtract a small decrement, flooring at zero so the score never wraps
  // downward.
  function automatic logic [CNT_W-1:0] floor_sub(input logic [CNT_W-1:0] a,
                                                 input logic [1:0] dec);
    logic [CNT_W:0] decWide;
    logic [CNT_W:0] diff;
    decWide = {{(CNT_W-1){1'b0}}, dec};
    diff    = {1'b0, a} - decWide;
    if ({1'b0, a} < decWide) return '0;
    return diff[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
// Bundles the session controller's control inputs (from buttons and the
// keyboard/compare stage) and its registered info-panel outputs.
// Signals:
//   go          single-cycle start/pause/resume/acknowledge pulse
//   mode_sel    requested mode (00 AMA, 01 PRO, 10 EDL, 11 illegal)
//   mode_load   single-cycle pulse latching mode_sel
//   key_valid   single-cycle pulse, one keystroke judged
//   key_hit     qualifies key_valid: 1 correct, 0 miss
//   start       high in RUN and OVER
//   end_game    high only in OVER
//   count_time  elapsed whole seconds
//   presscount  keystrokes this round
//   misscount   misses this round
//   score       current score
//   mode        active mode
// Modports: master drives the controls and observes the panel; slave is
// the controller itself.
// ---------------------------------------------------------------------------
interface game_ctrl_if;
  logic        go;
  logic [1:0]  mode_sel;
  logic        mode_load;
  logic        key_valid;
  logic        key_hit;
  logic        start;
  logic        end_game;
  logic [13:0] count_time;
  logic [13:0] presscount;
  logic [13:0] misscount;
  logic [13:0] score;
  logic [1:0]  mode;

  modport master (
    output go, mode_sel, mode_load, key_valid, key_hit,
    input  start, end_game, count_time, presscount, misscount, score, mode
  );

  modport slave (
    input  go, mode_sel, mode_load, key_valid, key_hit,
    output start, end_game, count_time, presscount, misscount, score, mode
  );
endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler that counts enabled clock cycles and emits a single-cycle tick
// on the enabled cycle where it sits at CLK_HZ-1, wrapping to 0 on that
// edge. When not enabled it holds its value, so a tick that was due while
// disabled fires on the first enabled cycle afterwards.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   enable  advance the prescaler this cycle
//   clear   force the prescaler to 0 (wins over enable, suppresses tick)
//   tick    combinational, high on the wrapping edge
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next prescaler value: clear has priority, otherwise count up while
  // enabled and wrap after the last cycle of the second.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Session controller for the typing game. Sequences IDLE -> RUN <-> PAUSE,
// RUN -> OVER -> IDLE, keeps the one-second game clock via tick_gen, and
// maintains saturating press/miss/score counters. Every panel output comes
// straight from a register, so an accepted event shows up the cycle after
// its sampling edge.
// Parameters:
//   CLK_HZ        clock cycles per game second
//   GAME_SECONDS  round length in seconds (1..5999)
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, overrides everything
//   bus    game_ctrl_if.slave: controls in, panel values out
// ---------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int GAME_SECONDS = 60
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] GAME_SEC = CNT_W'(GAME_SECONDS);

  state_e           state_q,      state_d;
  logic             start_q,      start_d;
  logic             endGame_q,    endGame_d;
  logic [CNT_W-1:0] countTime_q,  countTime_d;
  logic [CNT_W-1:0] pressCount_q, pressCount_d;
  logic [CNT_W-1:0] missCount_q,  missCount_d;
  logic [CNT_W-1:0] score_q,      score_d;
  logic [1:0]       mode_q,       mode_d;

  logic             roundStart;
  logic             prescEnable;
  logic             secTick;
  logic             keyAccept;
  logic [CNT_W-1:0] timeNext;

  // A new round zeroes the prescaler on the same edge it zeroes the
  // counters. The prescaler is frozen on any edge where go is seen in RUN:
  // go beats a due tick, and the held CLK_HZ-1 value makes that tick fire
  // on the first RUN edge after resuming, so PAUSE time never counts.
  assign roundStart  = (state_q == ST_IDLE) && bus.go;
  assign prescEnable = (state_q == ST_RUN) && !bus.go;
  assign keyAccept   = (state_q == ST_RUN) && bus.key_valid;
  assign timeNext    = sat_add(countTime_q, 2'd1);

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (prescEnable),
    .clear  (roundStart),
    .tick   (secTick)
  );

  // Next-state and counter update logic. Keystrokes are scored before the
  // state decision so a key coinciding with go or with the final tick is
  // still counted. start/end_game are derived from the next state so they
  // switch on the same edge as the state register.
  always_comb begin
    state_d      = state_q;
    countTime_d  = countTime_q;
    pressCount_d = pressCount_q;
    missCount_d  = missCount_q;
    score_d      = score_q;
    mode_d       = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.mode_load && (bus.mode_sel != MODE_ILLEGAL)) begin
          mode_d = bus.mode_sel;
        end
        if (bus.go) begin
          state_d      = ST_RUN;
          countTime_d  = '0;
          pressCount_d = '0;
          missCount_d  = '0;
          score_d      = '0;
        end
      end

      ST_RUN: begin
        if (keyAccept) begin
          pressCount_d = sat_add(pressCount_q, 2'd1);
          if (bus.key_hit) begin
            score_d = sat_add(score_q, hit_weight(mode_q));
          end else begin
            missCount_d = sat_add(missCount_q, 2'd1);
            score_d     = floor_sub(score_q, miss_penalty(mode_q));
          end
        end
        if (bus.go) begin
          state_d = ST_PAUSE;
        end else if (secTick) begin
          countTime_d = timeNext;
          if (timeNext == GAME_SEC) begin
            state_d = ST_OVER;
          end
        end
      end

      ST_PAUSE: begin
        if (bus.go) begin
          state_d = ST_RUN;
        end
      end

      ST_OVER: begin
        if (bus.go) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d   = (state_d == ST_RUN) || (state_d == ST_OVER);
    endGame_d = (state_d == ST_OVER);
  end

  // State, flag and counter registers; reset returns the whole panel to
  // its idle values on the next edge, even mid-round.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      endGame_q    <= 1'b0;
      countTime_q  <= '0;
      pressCount_q <= '0;
      missCount_q  <= '0;
      score_q      <= '0;
      mode_q       <= MODE_AMA;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      endGame_q    <= endGame_d;
      countTime_q  <= countTime_d;
      pressCount_q <= pressCount_d;
      missCount_q  <= missCount_d;
      score_q      <= score_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.start      = start_q;
  assign bus.end_game   = endGame_q;
  assign bus.count_time = countTime_q;
  assign bus.presscount = pressCount_q;
  assign bus.misscount  = missCount_q;
  assign bus.score      = score_q;
  assign bus.mode       = mode_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
// Drives two game_ctrl instances from one clock: unit A with a 3-second
// round for the timing scenarios, unit B with a long round for scoring and
// saturation. A reference model counts RUN cycles and derives seconds by
// division, scoring by plain integer min/max.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

  localparam int HZ      = 4;
  localparam int GS_A    = 3;
  localparam int GS_B    = 5999;
  localparam int CEIL    = 9999;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_OVER  = 3;

  typedef struct packed {
    logic       go;
    logic [1:0] ms;
    logic       ml;
    logic       kv;
    logic       kh;
  } stim_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int checks   = 0;
  int failures = 0;

  int mState [2];
  int mRun   [2];
  int mTime  [2];
  int mPress [2];
  int mMiss  [2];
  int mScore [2];
  int mMode  [2];
  int gsOf   [2];
  int weightOf  [3] = '{1, 2, 3};
  int penaltyOf [3] = '{0, 1, 2};

  stim_t idleS;
  stim_t goS;

  always #5 clk = ~clk;

  game_ctrl_if ifA ();
  game_ctrl_if ifB ();

  game_ctrl #(.CLK_HZ(HZ), .GAME_SECONDS(GS_A)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.slave)
  );

  game_ctrl #(.CLK_HZ(HZ), .GAME_SECONDS(GS_B)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.slave)
  );

  function automatic stim_t mk(input logic g, input logic [1:0] ms,
                               input logic ml, input logic kv, input logic kh);
    stim_t s;
    s.go = g; s.ms = ms; s.ml = ml; s.kv = kv; s.kh = kh;
    return s;
  endfunction

  function automatic stim_t randStim(input int goOdds);
    stim_t s;
    s.go = ($urandom % goOdds) == 0;
    s.ms = 2'($urandom);
    s.ml = ($urandom % 6) == 0;
    s.kv = 1'($urandom);
    s.kh = 1'($urandom);
    return s;
  endfunction

  function automatic logic [59:0] obsOf(input int u);
    if (u == 0)
      return {ifA.start, ifA.end_game, ifA.count_time, ifA.presscount,
              ifA.misscount, ifA.score, ifA.mode};
    return {ifB.start, ifB.end_game, ifB.count_time, ifB.presscount,
            ifB.misscount, ifB.score, ifB.mode};
  endfunction

  function automatic logic [59:0] expOf(input int u);
    logic st;
    logic en;
    st = (mState[u] == S_RUN) || (mState[u] == S_OVER);
    en = (mState[u] == S_OVER);
    return {st, en, 14'(mTime[u]), 14'(mPress[u]), 14'(mMiss[u]),
            14'(mScore[u]), 2'(mMode[u])};
  endfunction

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      mState[u] = S_IDLE; mRun[u] = 0; mTime[u] = 0; mPress[u] = 0;
      mMiss[u] = 0; mScore[u] = 0; mMode[u] = 0;
    end
  endtask

  // Model of one edge: seconds are RUN cycles divided by HZ, round ends
  // once the RUN cycle count equals seconds * HZ.
  task automatic modelStep(input int u, input stim_t s);
    case (mState[u])
      S_IDLE: begin
        if (s.ml && s.ms != 2'b11) mMode[u] = int'(s.ms);
        if (s.go) begin
          mState[u] = S_RUN; mRun[u] = 0; mTime[u] = 0;
          mPress[u] = 0; mMiss[u] = 0; mScore[u] = 0;
        end
      end
      S_RUN: begin
        if (s.kv) begin
          mPress[u] = (mPress[u] + 1 > CEIL) ? CEIL : mPress[u] + 1;
          if (s.kh) begin
            mScore[u] = (mScore[u] + weightOf[mMode[u]] > CEIL) ? CEIL
                        : mScore[u] + weightOf[mMode[u]];
          end else begin
            mMiss[u]  = (mMiss[u] + 1 > CEIL) ? CEIL : mMiss[u] + 1;
            mScore[u] = (mScore[u] - penaltyOf[mMode[u]] < 0) ? 0
                        : mScore[u] - penaltyOf[mMode[u]];
          end
        end
        if (s.go) begin
          mState[u] = S_PAUSE;
        end else begin
          mRun[u]++;
          mTime[u] = mRun[u] / HZ;
          if (mRun[u] == gsOf[u] * HZ) mState[u] = S_OVER;
        end
      end
      S_PAUSE: if (s.go) mState[u] = S_RUN;
      default: if (s.go) mState[u] = S_IDLE;
    endcase
  endtask

  task automatic setInputs(input stim_t a, input stim_t b);
    ifA.go = a.go; ifA.mode_sel = a.ms; ifA.mode_load = a.ml;
    ifA.key_valid = a.kv; ifA.key_hit = a.kh;
    ifB.go = b.go; ifB.mode_sel = b.ms; ifB.mode_load = b.ml;
    ifB.key_valid = b.kv; ifB.key_hit = b.kh;
  endtask

  // Present one cycle of stimulus to both units, advance the model, and
  // return 1 time unit after the edge with pulses dropped.
  task automatic applyStimulus(input stim_t a, input stim_t b);
    setInputs(a, b);
    modelStep(0, a);
    modelStep(1, b);
    @(posedge clk);
    #1;
    setInputs(idleS, idleS);
  endtask

  task automatic stepA(input stim_t a);
    applyStimulus(a, idleS);
  endtask

  task automatic stepB(input stim_t b);
    applyStimulus(idleS, b);
  endtask

  task automatic doReset();
    reset = 1'b1;
    setInputs(idleS, idleS);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obsOf(u) !== 60'd0) begin
        failures++;
        $display("[TB] FAIL reset_unit%0d: got %h expected %h", u, obsOf(u), 60'd0);
      end
    end
  endtask

  task automatic test_timing();
    stepA(goS);
    checks++;
    if (ifA.start !== 1'b1 || ifA.end_game !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_rise: got start=%b end=%b expected 1/0", ifA.start, ifA.end_game);
    end
    repeat (4) stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd1) begin
      failures++;
      $display("[TB] FAIL time_after_4: got %0d expected 1", ifA.count_time);
    end
    repeat (7) stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd2 || ifA.end_game !== 1'b0) begin
      failures++;
      $display("[TB] FAIL before_final: got time=%0d end=%b expected 2/0", ifA.count_time, ifA.end_game);
    end
    stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd3 || ifA.end_game !== 1'b1 || ifA.start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL final_tick: got time=%0d end=%b start=%b expected 3/1/1",
               ifA.count_time, ifA.end_game, ifA.start);
    end
    stepA(idleS);
    stepA(goS);
    checks++;
    if (obsOf(0) !== expOf(0) || ifA.count_time !== 14'd3 || ifA.start !== 1'b0) begin
      failures++;
      $display("[TB] FAIL over_ack: got %h expected %h", obsOf(0), expOf(0));
    end
  endtask

  task automatic test_scoring();
    stim_t seq [7];
    stim_t tmp;
    int j;
    stepB(mk(1'b1, 2'b01, 1'b1, 1'b0, 1'b0));
    checks++;
    if (ifB.mode !== 2'b01 || ifB.start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL go_with_load: got mode=%b start=%b expected 01/1", ifB.mode, ifB.start);
    end
    for (int i = 0; i < 7; i++) seq[i] = mk(1'b0, 2'b00, 1'b0, 1'b1, (i < 5));
    for (int i = 6; i > 1; i--) begin
      j = 1 + int'($urandom % i);
      tmp = seq[i]; seq[i] = seq[j]; seq[j] = tmp;
    end
    for (int i = 0; i < 7; i++) begin
      stepB(seq[i]);
      repeat ($urandom % 3) stepB(idleS);
    end
    checks++;
    if (ifB.presscount !== 14'd7 || ifB.misscount !== 14'd2 || ifB.score !== 14'd8) begin
      failures++;
      $display("[TB] FAIL pro_score: got p=%0d m=%0d s=%0d expected 7/2/8",
               ifB.presscount, ifB.misscount, ifB.score);
    end
    repeat (10) stepB(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    checks++;
    if (ifB.score !== 14'd0 || ifB.misscount !== 14'd12 || obsOf(1) !== expOf(1)) begin
      failures++;
      $display("[TB] FAIL score_floor: got %h expected %h", obsOf(1), expOf(1));
    end
  endtask

  task automatic test_saturation();
    doReset();
    stepB(mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
    repeat (CEIL) stepB(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1));
    checks++;
    if (ifB.presscount !== 14'd9999 || ifB.score !== 14'd9999) begin
      failures++;
      $display("[TB] FAIL reach_ceiling: got p=%0d s=%0d expected 9999/9999", ifB.presscount, ifB.score);
    end
    repeat (3) stepB(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1));
    checks++;
    if (ifB.presscount !== 14'd9999 || ifB.score !== 14'd9999 || obsOf(1) !== expOf(1)) begin
      failures++;
      $display("[TB] FAIL hold_ceiling: got %h expected %h", obsOf(1), expOf(1));
    end
  endtask

  task automatic test_pause();
    stim_t s;
    doReset();
    stepA(goS);
    repeat (6) stepA(idleS);
    stepA(goS);
    checks++;
    if (ifA.start !== 1'b0 || ifA.count_time !== 14'd1) begin
      failures++;
      $display("[TB] FAIL pause_entry: got start=%b time=%0d expected 0/1", ifA.start, ifA.count_time);
    end
    for (int i = 0; i < 20; i++) begin
      s = randStim(2);
      s.go = 1'b0;
      s.kv = 1'b1;
      stepA(s);
      checks++;
      if (obsOf(0) !== expOf(0) || ifA.presscount !== 14'd0) begin
        failures++;
        $display("[TB] FAIL paused_%0d: got %h expected %h", i, obsOf(0), expOf(0));
      end
    end
    stepA(goS);
    repeat (5) stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd2 || ifA.end_game !== 1'b0 || ifA.start !== 1'b1) begin
      failures++;
      $display("[TB] FAIL resume_5: got time=%0d end=%b expected 2/0", ifA.count_time, ifA.end_game);
    end
    stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd3 || ifA.end_game !== 1'b1) begin
      failures++;
      $display("[TB] FAIL resume_6: got time=%0d end=%b expected 3/1", ifA.count_time, ifA.end_game);
    end
    stepA(goS);
  endtask

  task automatic test_go_tick();
    stepA(goS);
    repeat (3) stepA(idleS);
    stepA(mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b1));
    checks++;
    if (ifA.start !== 1'b0 || ifA.count_time !== 14'd0 || ifA.presscount !== 14'd1 || ifA.score !== 14'd1) begin
      failures++;
      $display("[TB] FAIL go_on_tick: got %h expected start=0 time=0 press=1 score=1", obsOf(0));
    end
    stepA(goS);
    stepA(idleS);
    checks++;
    if (ifA.count_time !== 14'd1) begin
      failures++;
      $display("[TB] FAIL tick_after_resume: got %0d expected 1", ifA.count_time);
    end
    repeat (7) stepA(idleS);
    stepA(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    checks++;
    if (ifA.end_game !== 1'b1 || ifA.count_time !== 14'd3 || ifA.presscount !== 14'd2 ||
        ifA.misscount !== 14'd1 || ifA.score !== 14'd1) begin
      failures++;
      $display("[TB] FAIL key_on_final: got %h expected %h", obsOf(0), expOf(0));
    end
    stepA(goS);
  endtask

  task automatic test_mode();
    stepA(mk(1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
    checks++;
    if (ifA.mode !== 2'b10) begin
      failures++;
      $display("[TB] FAIL load_edl: got %b expected 10", ifA.mode);
    end
    stepA(mk(1'b0, 2'b11, 1'b1, 1'b0, 1'b0));
    checks++;
    if (ifA.mode !== 2'b10) begin
      failures++;
      $display("[TB] FAIL load_illegal: got %b expected 10", ifA.mode);
    end
    stepA(goS);
    stepA(mk(1'b0, 2'b01, 1'b1, 1'b1, 1'b1));
    stepA(mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1));
    checks++;
    if (ifA.mode !== 2'b10 || ifA.score !== 14'd6) begin
      failures++;
      $display("[TB] FAIL load_in_run: got mode=%b score=%0d expected 10/6", ifA.mode, ifA.score);
    end
    doReset();
    checks++;
    if (obsOf(0) !== 60'd0 || obsOf(1) !== 60'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got %h / %h expected 0", obsOf(0), obsOf(1));
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 800; i++) begin
      if (($urandom % 300) == 0) doReset();
      else applyStimulus(randStim(12), randStim(40));
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obsOf(u) !== expOf(u)) begin
          failures++;
          $display("[TB] FAIL random_u%0d_c%0d: got %h expected %h", u, i, obsOf(u), expOf(u));
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleS   = '0;
    goS     = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    gsOf[0] = GS_A;
    gsOf[1] = GS_B;
    setInputs(idleS, idleS);
    modelReset();
    test_reset();
    test_timing();
    test_scoring();
    test_saturation();
    test_pause();
    test_go_tick();
    test_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
